// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM single-port memory arbiter.
// Bus widths of mem_req_t follow the package defaults below.
package mem_arb_pkg;

    localparam int ARB_ADDR_WIDTH = 10;
    localparam int ARB_DATA_WIDTH = 32;
    localparam int CNT_W          = 3;

    typedef enum logic {ARB_IDLE, ARB_RD_WAIT} arb_state_e;
    typedef enum logic {OWN_IF, OWN_D} arb_owner_e;

    typedef struct packed {
        logic                      we;
        logic [ARB_ADDR_WIDTH-1:0] addr;
        logic [ARB_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request ports and memory-macro bus of the arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_tracker.sv
// Latency counter and owner flag of the single outstanding read;
// decodes the final wait cycle into the owner's rvalid pulse.
module mem_arb_tracker
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       load,
    input  arb_owner_e load_owner,
    input  logic       active,
    output logic       last,
    output logic       if_rvalid,
    output logic       d_rvalid
);

    logic [CNT_W-1:0] cnt;
    arb_owner_e       owner;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt   <= '0;
            owner <= OWN_IF;
        end else if (load) begin
            cnt   <= CNT_W'(MEM_LATENCY);
            owner <= load_owner;
        end else if (active && (cnt != '0)) begin
            cnt   <= cnt - 1'b1;
        end
    end

    // Counter reads 1 in the cycle mem_rdata is valid.
    assign last      = active && (cnt == CNT_W'(1));
    assign if_rvalid = last && (owner == OWN_IF);
    assign d_rvalid  = last && (owner == OWN_D);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF reads and MEM-stage ld/sd,
// data side first. ARB_STARVE_GUARD_EN lets IF win once after STARVE_LIMIT data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_b,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);

    arb_state_e state, state_nxt;
    logic       issue_ok;
    logic       if_first;
    logic       read_issue;
    logic       last;
    logic       if_rvalid;
    logic       d_rvalid;
    mem_req_t   sel;

`ifdef ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            starve_cnt <= '0;
        end else if (!bus.if_req || bus.if_gnt) begin
            starve_cnt <= '0;
        end else if (bus.d_gnt && (starve_cnt != '1)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign if_first = bus.if_req && bus.d_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign if_first = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= ARB_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        issue_ok      = (state == ARB_IDLE) || last;
        bus.d_gnt     = issue_ok && bus.d_req && !if_first;
        bus.if_gnt    = issue_ok && bus.if_req && !bus.d_gnt;
        read_issue    = (bus.d_gnt && !bus.d_we) || bus.if_gnt;
        sel           = '0;
        if (bus.d_gnt) begin
            sel = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};
        end else if (bus.if_gnt) begin
            sel = '{we: 1'b0, addr: bus.if_addr, wdata: '0};
        end
        bus.mem_en    = bus.d_gnt || bus.if_gnt;
        bus.mem_we    = sel.we;
        bus.mem_addr  = sel.addr;
        bus.mem_wdata = sel.wdata;

        state_nxt = ARB_IDLE;
        if (read_issue)                          state_nxt = ARB_RD_WAIT;
        else if ((state == ARB_RD_WAIT) && !last) state_nxt = ARB_RD_WAIT;
    end

    mem_arb_tracker #(.MEM_LATENCY(MEM_LATENCY)) u_tracker (
        .clk        (clk),
        .reset_b    (reset_b),
        .load       (read_issue),
        .load_owner (bus.d_gnt ? OWN_D : OWN_IF),
        .active     (state == ARB_RD_WAIT),
        .last       (last),
        .if_rvalid  (if_rvalid),
        .d_rvalid   (d_rvalid)
    );

    assign busy          = (state == ARB_RD_WAIT);
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_rvalid  ? bus.mem_rdata : '0;

    // Requesters must hold request and payload until granted.
    a_if_hold: assert property (@(posedge clk) disable iff (!reset_b)
        (bus.if_req && !bus.if_gnt) |=> (bus.if_req && $stable(bus.if_addr)));
    a_d_hold: assert property (@(posedge clk) disable iff (!reset_b)
        (bus.d_req && !bus.d_gnt) |=> (bus.d_req && $stable(bus.d_we)
            && $stable(bus.d_addr) && $stable(bus.d_wdata)));
    a_params: assert property (@(posedge clk)
        (MEM_LATENCY >= 1) && (MEM_LATENCY <= 7) && (STARVE_LIMIT <= 7));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency-1 and latency-3 instances,
// starvation pattern expectation follows ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_b1, reset_b3;
    logic busy1, busy3;
    logic exp_if;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus1 ();
    mem_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus3 ();

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_lat1 (
        .clk     (clk),
        .reset_b (reset_b1),
        .bus     (bus1.slave),
        .busy    (busy1)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_lat3 (
        .clk     (clk),
        .reset_b (reset_b3),
        .bus     (bus3.slave),
        .busy    (busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_b1 = 1'b0;
        reset_b3 = 1'b0;
        bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_rdata = '0;
        bus3.if_req = 0; bus3.if_addr = '0; bus3.d_req = 0; bus3.d_we = 0;
        bus3.d_addr = '0; bus3.d_wdata = '0; bus3.mem_rdata = '0;

        // Reset state
        @(negedge clk); #1;
        check("rst_busy1",   busy1, 0);
        check("rst_if_gnt",  bus1.if_gnt, 0);
        check("rst_d_gnt",   bus1.d_gnt, 0);
        check("rst_mem_en",  bus1.mem_en, 0);
        check("rst_mem_addr", bus1.mem_addr, 0);
        check("rst_if_rv",   bus1.if_rvalid, 0);
        check("rst_d_rv",    bus1.d_rvalid, 0);
        check("rst_busy3",   busy3, 0);

        // 1: IF read at reset release, latency 1
        @(negedge clk);
        reset_b1 = 1'b1; bus1.if_req = 1; bus1.if_addr = 10'h004;
        #1;
        check("t1_if_gnt",   bus1.if_gnt, 1);
        check("t1_mem_en",   bus1.mem_en, 1);
        check("t1_mem_we",   bus1.mem_we, 0);
        check("t1_mem_addr", bus1.mem_addr, 32'h004);
        check("t1_busy0",    busy1, 0);
        @(negedge clk);
        bus1.if_req = 0; bus1.if_addr = '0; bus1.mem_rdata = 32'h0000_0013;
        #1;
        check("t1_if_rv",    bus1.if_rvalid, 1);
        check("t1_if_rdata", bus1.if_rdata, 32'h0000_0013);
        check("t1_d_rdata",  bus1.d_rdata, 0);
        check("t1_busy1",    busy1, 1);
        @(negedge clk);
        bus1.mem_rdata = '0;
        #1;
        check("t1_if_rv_end", bus1.if_rvalid, 0);
        check("t1_busy_end",  busy1, 0);

        // 2: simultaneous requests, data side first
        @(negedge clk);
        bus1.if_req = 1; bus1.if_addr = 10'h008;
        bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 10'h010;
        #1;
        check("t2_d_gnt",    bus1.d_gnt, 1);
        check("t2_if_gnt0",  bus1.if_gnt, 0);
        check("t2_mem_addr", bus1.mem_addr, 32'h010);
        @(negedge clk);
        bus1.d_req = 0; bus1.d_addr = '0; bus1.mem_rdata = 32'hAAAA_5555;
        #1;
        check("t2_d_rv",     bus1.d_rvalid, 1);
        check("t2_d_rdata",  bus1.d_rdata, 32'hAAAA_5555);
        check("t2_if_rdata0", bus1.if_rdata, 0);
        check("t2_if_gnt",   bus1.if_gnt, 1);
        check("t2_if_addr",  bus1.mem_addr, 32'h008);
        @(negedge clk);
        bus1.if_req = 0; bus1.if_addr = '0; bus1.mem_rdata = 32'h1111_2222;
        #1;
        check("t2_if_rv",    bus1.if_rvalid, 1);
        check("t2_if_rdata", bus1.if_rdata, 32'h1111_2222);
        check("t2_d_rv0",    bus1.d_rvalid, 0);
        @(negedge clk);
        bus1.mem_rdata = '0;

        // 6: both requests held; guard gives IF one slot after four data grants
        @(negedge clk);
        bus1.if_req = 1; bus1.if_addr = 10'h100;
        bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 10'h200;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            #1;
`ifdef ARB_STARVE_GUARD_EN
            exp_if = ((k % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            check("t6_d_gnt",  bus1.d_gnt, !exp_if);
            check("t6_if_gnt", bus1.if_gnt, exp_if);
        end
        @(negedge clk);
        bus1.d_req = 0; bus1.d_addr = '0;
        #1;
        check("t6_if_gnt_drain", bus1.if_gnt, 1);
        check("t6_if_addr",      bus1.mem_addr, 32'h100);
        @(negedge clk);
        bus1.if_req = 0; bus1.if_addr = '0; bus1.mem_rdata = 32'h0000_0055;
        #1;
        check("t6_if_rv", bus1.if_rvalid, 1);
        @(negedge clk);
        bus1.mem_rdata = '0;

        // 3: store at latency 3, then IF read next cycle
        @(negedge clk);
        reset_b3 = 1'b1;
        #1;
        check("t3_busy_rel", busy3, 0);
        @(negedge clk);
        bus3.d_req = 1; bus3.d_we = 1; bus3.d_addr = 10'h020; bus3.d_wdata = 32'hDEAD_BEEF;
        bus3.if_req = 1; bus3.if_addr = 10'h030;
        #1;
        check("t3_d_gnt",     bus3.d_gnt, 1);
        check("t3_if_gnt0",   bus3.if_gnt, 0);
        check("t3_mem_we",    bus3.mem_we, 1);
        check("t3_mem_addr",  bus3.mem_addr, 32'h020);
        check("t3_mem_wdata", bus3.mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        bus3.d_req = 0; bus3.d_we = 0; bus3.d_addr = '0; bus3.d_wdata = '0;
        #1;
        check("t3_busy_store", busy3, 0);
        check("t3_d_rv0",      bus3.d_rvalid, 0);
        check("t3_if_gnt",     bus3.if_gnt, 1);
        check("t3_if_we",      bus3.mem_we, 0);
        check("t3_if_addr",    bus3.mem_addr, 32'h030);

        // 4: data request held behind a latency-3 IF read
        @(negedge clk);
        bus3.if_req = 0; bus3.if_addr = '0;
        bus3.d_req = 1; bus3.d_addr = 10'h040;
        #1;
        check("t4_busy",     busy3, 1);
        check("t4_d_gnt_w1", bus3.d_gnt, 0);
        check("t4_mem_en0",  bus3.mem_en, 0);
        @(negedge clk); #1;
        check("t4_d_gnt_w2", bus3.d_gnt, 0);
        check("t4_if_rv_w2", bus3.if_rvalid, 0);
        @(negedge clk);
        bus3.mem_rdata = 32'h600D_F00D;
        #1;
        check("t4_if_rv",    bus3.if_rvalid, 1);
        check("t4_if_rdata", bus3.if_rdata, 32'h600D_F00D);
        check("t4_d_gnt",    bus3.d_gnt, 1);
        check("t4_mem_addr", bus3.mem_addr, 32'h040);
        @(negedge clk);
        bus3.d_req = 0; bus3.d_addr = '0; bus3.mem_rdata = '0;
        #1;
        check("t4_busy_ld",  busy3, 1);
        check("t4_d_rv_e1",  bus3.d_rvalid, 0);
        @(negedge clk); #1;
        check("t4_d_rv_e2",  bus3.d_rvalid, 0);
        @(negedge clk);
        bus3.mem_rdata = 32'hCAFE_F00D;
        #1;
        check("t4_d_rv",     bus3.d_rvalid, 1);
        check("t4_d_rdata",  bus3.d_rdata, 32'hCAFE_F00D);
        check("t4_if_rv0",   bus3.if_rvalid, 0);
        @(negedge clk);
        bus3.mem_rdata = '0;
        #1;
        check("t4_busy_end", busy3, 0);

        // 5: reset during a latency-3 read discards it
        @(negedge clk);
        bus3.if_req = 1; bus3.if_addr = 10'h050;
        #1;
        check("t5_if_gnt", bus3.if_gnt, 1);
        @(negedge clk);
        bus3.if_req = 0; bus3.if_addr = '0; bus3.mem_rdata = 32'h0000_0077;
        #1;
        check("t5_busy_pre", busy3, 1);
        reset_b3 = 1'b0;
        #1;
        check("t5_busy_rst", busy3, 0);
        check("t5_rv_rst",   bus3.if_rvalid, 0);
        @(negedge clk);
        reset_b3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t5_if_rv_none", bus3.if_rvalid, 0);
            check("t5_if_rdata0",  bus3.if_rdata, 0);
            check("t5_busy_none",  busy3, 0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
